down_count_checker: RTL
=======================

Name: down_count_checker

Overview:
- Sits directly downstream of the 4-bit synchronous down counter.
- Samples the counter's 4-bit output every clock and checks that each step is exactly prev-1 mod 16, or a permitted hold.
- Flags wrap-around events (0 -> 15) and sequence faults, and keeps wrap and error tallies.
- Used as a self-check / lab monitor stage on the counter output bus, in the same clock domain as the counter.

Parameters:
WRAP_W, 8, width of wrap event counter (wraps modulo 2^WRAP_W)
ERR_W, 4, width of error counter (saturates at all-ones)
RECOVER, 4, consecutive good samples required to leave FAULT (1..15)
ALLOW_HOLD, 1, 1 = qIn equal to prev counts as good; 0 = hold is an error

Ports:
clk  input  1  rising-edge clock, same clock as the counter
rst  input  1  asynchronous active-low reset
qIn  input  4  counter value under check
clr  input  1  synchronous clear of state and tallies, active-high
wrapPulse  output  1  one-cycle pulse on a 0 -> 15 step
wrapCount  output  WRAP_W  number of wraps seen, modulo 2^WRAP_W
errPulse  output  1  one-cycle pulse on an illegal step
errCount  output  ERR_W  number of illegal steps, saturating
fault  output  1  high while the state machine is in FAULT
state  output  2  encoded state: 00 SYNC, 01 TRACK, 10 FAULT

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-low.
- On rst low, all of the following hold immediately, independent of clk:
  - state = SYNC
  - prev = 0
  - wrapPulse = 0, errPulse = 0, fault = 0
  - wrapCount = 0, errCount = 0
  - internal good-run counter = 0
- Outputs are fully registered. A verdict on qIn sampled at edge k is visible right after edge k, with no combinational path from qIn to any output.
- clr has priority over all other activity at an edge:
  - state <= SYNC; both tallies <= 0; both pulses <= 0; good-run counter <= 0.
  - prev is not loaded on a clr edge.
- Step classification, used in TRACK and FAULT:
  - step = (qIn == prev - 1 mod 16)
  - hold = (qIn == prev) && ALLOW_HOLD
  - good = step || hold
  - wrap = step && prev == 0 && qIn == 15
- SYNC:
  - prev <= qIn; pulses <= 0; no check performed.
  - Next state is TRACK. This occupies exactly one cycle after reset release or after clr.
- TRACK:
  - prev <= qIn.
  - wrapPulse <= wrap; wrapCount increments on wrap.
  - errPulse <= !good.
  - On !good: errCount increments, saturating at 2^ERR_W - 1; state <= FAULT; good-run <= 0.
- FAULT:
  - fault = 1. Checking and wrap counting continue exactly as in TRACK.
  - On good: good-run increments; when good-run reaches RECOVER, state <= TRACK and good-run <= 0.
  - On !good: errPulse, errCount increment, good-run <= 0; stay in FAULT.
- Pulses:
  - Never asserted for two consecutive cycles unless the condition recurs.
  - wrapPulse and errPulse are mutually exclusive.
- Counter wrap-around:
  - wrapCount rolls over silently, all-ones -> 0.
  - errCount holds at all-ones.
- Counter held in its own reset (qIn stuck at 0):
  - Counts as hold: good if ALLOW_HOLD = 1, one error per cycle otherwise.
- Reset asserted mid-operation: immediate return to the reset values above. The first check after release is the second sample, because SYNC consumes the first.

Optional Feature:
DOWN_CHK_SNAPSHOT_EN
- Defined:
  - Adds outputs snapExp[3:0] and snapGot[3:0], both reset to 0 and cleared by clr.
  - On the first error since reset/clr: snapExp latches prev-1 mod 16 and snapGot latches qIn.
  - Later errors do not overwrite the snapshot.
- Undefined:
  - The ports and their registers do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset release, qIn driven 15,14,...,0,15,14 one per clock -> state SYNC then TRACK; errCount = 0; single wrapPulse on the 0 -> 15 step; wrapCount = 1.
- Sequence 9,8,5,4,3,2,1 (RECOVER = 4) -> errPulse once after sample 5; fault high; fault and state return to TRACK after the 4th good step (sample 1); errCount = 1.
- ALLOW_HOLD = 0, qIn held at 0 for 20 cycles after SYNC -> errCount saturates at 15; fault stays 1; no wrapPulse.
- Run 16 full down cycles with WRAP_W = 4 -> wrapCount reads 0 after the 16th wrap; no errors.
- Assert clr one cycle mid-FAULT with errCount = 3 -> next cycle state = SYNC, fault = 0, counts = 0; the following value is accepted unchecked.
- rst pulsed low asynchronously between edges during TRACK -> all outputs 0 immediately. With DOWN_CHK_SNAPSHOT_EN defined, a prior step 7 -> 3 had left snapExp = 6, snapGot = 3; both now read 0.

Source files
------------

// File: rtl/down_count_checker.sv
// down_count_checker: monitors a 4-bit down counter and checks each step is prev-1 mod 16 or a permitted hold.
// It flags wraps (0 -> 15) and illegal steps, and keeps a wrap tally and an error tally.
//
// Optional feature: `define DOWN_CHK_SNAPSHOT_EN adds the snapExp/snapGot
// capture of the first error since reset or clr.
//
// Ports:
//   clk       in   rising-edge clock, same clock as the counter
//   rst       in   asynchronous active-low reset
//   qIn       in   [3:0] counter value under check
//   clr       in   synchronous clear of state and tallies, active-high
//   wrapPulse out  one-cycle pulse on a 0 -> 15 step
//   wrapCount out  [WRAP_W-1:0] wraps seen, modulo 2^WRAP_W
//   errPulse  out  one-cycle pulse on an illegal step
//   errCount  out  [ERR_W-1:0] illegal steps, saturating
//   fault     out  high while in FAULT
//   state     out  [1:0] 00 SYNC, 01 TRACK, 10 FAULT
//   snapExp   out  [3:0] expected value at first error (snapshot build only)
//   snapGot   out  [3:0] observed value at first error (snapshot build only)

module down_count_checker #(
   parameter int unsigned WRAP_W     = 8,
   parameter int unsigned ERR_W      = 4,
   parameter int unsigned RECOVER    = 4,
   parameter bit          ALLOW_HOLD = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        qIn,
   input  logic              clr,
   output logic              wrapPulse,
   output logic [WRAP_W-1:0] wrapCount,
   output logic              errPulse,
   output logic [ERR_W-1:0]  errCount,
   output logic              fault,
   output logic [1:0]        state
`ifdef DOWN_CHK_SNAPSHOT_EN
   ,
   output logic [3:0]        snapExp,
   output logic [3:0]        snapGot
`endif
);

   typedef enum logic [1:0] {
      SYNC  = 2'b00,
      TRACK = 2'b01,
      FAULT = 2'b10
   } state_e;

   localparam logic [3:0] REC = 4'(RECOVER);

   state_e            state_q;
   logic [3:0]        prev_q;
   logic [3:0]        run_q;
   logic [WRAP_W-1:0] wrap_cnt_q;
   logic [ERR_W-1:0]  err_cnt_q;
   logic              wrap_pulse_q;
   logic              err_pulse_q;
   logic              fault_q;

   logic [3:0]        exp_val;
   logic              is_step;
   logic              is_hold;
   logic              is_good;
   logic              is_wrap;
   logic [3:0]        run_d;
   logic [WRAP_W-1:0] wrap_cnt_d;
   logic [ERR_W-1:0]  err_cnt_d;

`ifdef DOWN_CHK_SNAPSHOT_EN
   logic              snap_taken_q;
   logic [3:0]        snap_exp_q;
   logic [3:0]        snap_got_q;
`endif

   // Step classification against the previous sample; feeds registers only.
   always_comb begin
      exp_val    = prev_q - 4'd1;
      is_step    = (qIn == exp_val);
      is_hold    = ALLOW_HOLD && (qIn == prev_q);
      is_good    = is_step || is_hold;
      is_wrap    = is_step && (prev_q == 4'd0) && (qIn == 4'hF);
      run_d      = run_q + 4'd1;
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      // Error tally holds at all-ones.
      err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= SYNC;
         prev_q       <= 4'd0;
         run_q        <= 4'd0;
         wrap_cnt_q   <= '0;
         err_cnt_q    <= '0;
         wrap_pulse_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         fault_q      <= 1'b0;
`ifdef DOWN_CHK_SNAPSHOT_EN
         snap_taken_q <= 1'b0;
         snap_exp_q   <= 4'd0;
         snap_got_q   <= 4'd0;
`endif
      end else if (clr) begin
         // prev is deliberately left alone: SYNC reloads it next edge.
         state_q      <= SYNC;
         run_q        <= 4'd0;
         wrap_cnt_q   <= '0;
         err_cnt_q    <= '0;
         wrap_pulse_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         fault_q      <= 1'b0;
`ifdef DOWN_CHK_SNAPSHOT_EN
         snap_taken_q <= 1'b0;
         snap_exp_q   <= 4'd0;
         snap_got_q   <= 4'd0;
`endif
      end else begin
         unique case (state_q)
            SYNC: begin
               // First sample only seeds prev; nothing to compare against.
               prev_q       <= qIn;
               wrap_pulse_q <= 1'b0;
               err_pulse_q  <= 1'b0;
               fault_q      <= 1'b0;
               run_q        <= 4'd0;
               state_q      <= TRACK;
            end
            TRACK, FAULT: begin
               prev_q       <= qIn;
               wrap_pulse_q <= is_wrap;
               err_pulse_q  <= !is_good;
               if (is_wrap) begin
                  wrap_cnt_q <= wrap_cnt_d;
               end
               if (!is_good) begin
                  err_cnt_q <= err_cnt_d;
                  run_q     <= 4'd0;
                  state_q   <= FAULT;
                  fault_q   <= 1'b1;
`ifdef DOWN_CHK_SNAPSHOT_EN
                  if (!snap_taken_q) begin
                     snap_taken_q <= 1'b1;
                     snap_exp_q   <= exp_val;
                     snap_got_q   <= qIn;
                  end
`endif
               end else if (state_q == FAULT) begin
                  // Leave FAULT only after RECOVER good steps in a row.
                  if (run_d == REC) begin
                     run_q   <= 4'd0;
                     state_q <= TRACK;
                     fault_q <= 1'b0;
                  end else begin
                     run_q <= run_d;
                  end
               end
            end
            default: begin
               state_q      <= SYNC;
               run_q        <= 4'd0;
               wrap_pulse_q <= 1'b0;
               err_pulse_q  <= 1'b0;
               fault_q      <= 1'b0;
            end
         endcase
      end
   end

   assign wrapPulse = wrap_pulse_q;
   assign wrapCount = wrap_cnt_q;
   assign errPulse  = err_pulse_q;
   assign errCount  = err_cnt_q;
   assign fault     = fault_q;
   assign state     = state_q;

`ifdef DOWN_CHK_SNAPSHOT_EN
   assign snapExp = snap_exp_q;
   assign snapGot = snap_got_q;
`endif

endmodule
